regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning register count; AW = clog2(NREGS).
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 The block SHALL have parameter CW, default 2, meaning pending-write counter width per register; CMAX = 2^CW-1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-006 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- rs_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
- rs_data  out  NRD*XLEN  packed read data
- rs_busy  out  NRD  read operand has an outstanding write
- iss_valid  in  1  an instruction writing iss_rd issues this cycle
- iss_rd  in  AW  destination of the issuing instruction
- iss_ready  out  1  issue accepted this cycle
- wen  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- flush  in  1  discard all pending-write tracking
- stall  out  1  OR of rs_busy

Function
REQ-007 Register 0 SHALL read 0, ignore writes, never count as pending, and always accept issue.
REQ-008 Register writes SHALL occur on the rising clk edge when wen=1 and wr_addr!=0.
REQ-009 rs_data[i] SHALL be combinational: wr_data when wen=1 and wr_addr==rs_addr[i]!=0 (write-through bypass), else the stored value.
REQ-010 Each register r!=0 SHALL have a CW-bit pending counter cnt[r].
REQ-011 Increment condition: an issue fires when iss_valid=1 and iss_ready=1.
REQ-012 Decrement condition: a writeback counts when wen=1 and wr_addr!=0.
REQ-013 Next-state of cnt[r], without flush:
- +1 on an issue to r
- -1 on a writeback to r when cnt[r]>0
- unchanged when both hit r in the same cycle
- a writeback with cnt[r]=0 SHALL leave cnt at 0 (untracked write)
REQ-014 flush=1 SHALL set every cnt to 0 on the next edge, overriding issue and writeback to counters; the data write still occurs.
REQ-015 iss_ready SHALL be 0 only when iss_rd!=0, cnt[iss_rd]==CMAX, and no writeback to iss_rd occurs in the same cycle.
REQ-016 rs_busy[i] SHALL be 1 when rs_addr[i]!=0 and either:
- cnt>1, or
- cnt==1 and no same-cycle writeback to that address.
REQ-017 stall SHALL be the OR-reduction of rs_busy; all outputs except register storage are combinational from state and inputs, with zero-cycle latency.
REQ-018 Addresses >= NREGS SHALL read 0, report not busy, and be ignored for write and issue.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear all registers and counters.
REQ-020 During reset: rs_data=0, rs_busy=0, stall=0, iss_ready=1.
REQ-021 Reset asserted mid-operation SHALL discard all pending state with no recovery.
REQ-022 Deassertion SHALL take effect at the first rising edge with rst_n=1.

Structure
REQ-023 Default XLEN, NREGS, NRD and CW values and the x0 index constant SHALL live in the shared core package alongside the ALU op definitions.
REQ-024 The per-register pending counter (inc, dec, clr, sat) SHALL be one sub-module, sb_counter, instantiated NREGS-1 times.
REQ-025 Register storage and bypass logic SHALL be in the top module.

Verification
REQ-026 Write x5=0xDEADBEEF and read x5 on port 0 in the same cycle -> rs_data[0]=0xDEADBEEF; next cycle stored value also 0xDEADBEEF.
REQ-027 Write x0=0x1234 with iss_rd=0 -> x0 reads 0, rs_busy=0, iss_ready=1.
REQ-028 Issue x7 three times (CW=2) -> cnt=3; 4th issue -> iss_ready=0; 4th issue with simultaneous wen to x7 -> iss_ready=1 and cnt stays 3.
REQ-029 Issue x3, then read x3 on port 1 -> rs_busy[1]=1 and stall=1; same cycle as wen to x3 with 0x55 -> rs_busy[1]=0, rs_data[1]=0x55.
REQ-030 Issue x9 twice, then flush -> cnt[x9]=0 and rs_busy=0; a later wen to x9 leaves cnt at 0 and x9 is written.
REQ-031 With pending counts and data loaded, pulse rst_n low mid-cycle -> all reads 0 and stall=0 immediately, before any clock edge.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared core definitions: default register-file geometry, the x0 index and ALU op codes.
package regfile_sb_pkg;

    localparam int unsigned DefXlen  = 32;
    localparam int unsigned DefNregs = 32;
    localparam int unsigned DefNrd   = 2;
    localparam int unsigned DefCw    = 2;
    localparam int unsigned RegX0    = 0;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluSrl,
        AluSra,
        AluSlt,
        AluSltu
    } alu_op_e;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating increment, floor-at-zero decrement, sync clear.
module sb_counter
    import regfile_sb_pkg::*;
#(
    parameter int unsigned CW = DefCw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sat = (cnt_q == '1);
    assign cnt = cnt_q;

    // A decrement at zero is an untracked write and leaves the count alone.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !sat) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through bypass and a per-register pending-write scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int unsigned XLEN  = DefXlen,
    parameter  int unsigned NREGS = DefNregs,
    parameter  int unsigned NRD   = DefNrd,
    parameter  int unsigned CW    = DefCw,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                wen,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                flush,
    output logic                stall
);

    // x0 and out-of-range addresses are never stored, tracked or reported busy.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(RegX0)) && (32'(a) < NREGS);
    endfunction

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [CW-1:0]   cnt    [NREGS];
    logic [NREGS-1:0] sat;
    logic wb_fire;
    logic issue_fire;

    assign wb_fire    = wen && addr_ok(wr_addr);
    assign iss_ready  = !(addr_ok(iss_rd) && sat[iss_rd] && !(wb_fire && (wr_addr == iss_rd)));
    assign issue_fire = iss_valid && iss_ready && addr_ok(iss_rd);

    assign cnt[0] = '0;
    assign sat[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_counter #(
            .CW(CW)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (issue_fire && (iss_rd == AW'(r))),
            .dec  (wb_fire && (wr_addr == AW'(r))),
            .clr  (flush),
            .cnt  (cnt[r]),
            .sat  (sat[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_fire) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Outputs are gated by rst_n so a bypassed write cannot leak through during reset.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          wb_hit;
            a      = rs_addr[i*AW +: AW];
            wb_hit = wb_fire && (wr_addr == a);
            if (rst_n && addr_ok(a)) begin
                rs_data[i*XLEN +: XLEN] = wb_hit ? wr_data : regs_q[a];
                rs_busy[i] = (cnt[a] > CW'(1)) || ((cnt[a] == CW'(1)) && !wb_hit);
            end
        end
    end

    assign stall = |rs_busy;

endmodule
